// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift register sequencer: opcodes, FSM states and
// default geometry.
package shift_seq_pkg;

   localparam int DEF_WIDTH = 6;
   localparam int DEF_CNT_W = 4;

   localparam logic [2:0] OP_CLR  = 3'b000;
   localparam logic [2:0] OP_LOAD = 3'b001;
   localparam logic [2:0] OP_SHR  = 3'b010;
   localparam logic [2:0] OP_SHL  = 3'b011;
   localparam logic [2:0] OP_ROR  = 3'b100;
   localparam logic [2:0] OP_JOHN = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/shift_core.sv
// WIDTH-bit shift register datapath: applies one opcode per enabled edge and
// exposes the bit that the selected shift would push out.
module shift_core
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       op,
   input  logic             ser_in,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] q,
   output logic             ser_out
);

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_nxt_s;

   // next register value per opcode; illegal codes hold the value
   always_comb begin
      q_nxt_s = q_r;
      case (op)
         OP_CLR:  q_nxt_s = {WIDTH{1'b0}};
         OP_LOAD: q_nxt_s = load_data;
         OP_SHR:  q_nxt_s = {ser_in, q_r[WIDTH-1:1]};
         OP_SHL:  q_nxt_s = {q_r[WIDTH-2:0], ser_in};
         OP_ROR:  q_nxt_s = {q_r[0] | ser_in, q_r[WIDTH-1:1]};
         OP_JOHN: q_nxt_s = {~q_r[0] | ser_in, q_r[WIDTH-1:1]};
         default: q_nxt_s = q_r;
      endcase
   end

   // outgoing serial bit for the selected shift direction
   always_comb begin
      ser_out = 1'b0;
      case (op)
         OP_SHR, OP_ROR, OP_JOHN: ser_out = q_r[0];
         OP_SHL:                  ser_out = q_r[WIDTH-1];
         default:                 ser_out = 1'b0;
      endcase
   end

   // register storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_r <= {WIDTH{1'b0}};
      end else if (en) begin
         q_r <= q_nxt_s;
      end else begin
         q_r <= q_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command sequencer for a shift register: valid/ready command intake, repeat
// count for shift operations, abort handling and done/err pulse generation.
module shift_reg_sequencer
   import shift_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ser_in,
   input  logic             abort,
   output logic [WIDTH-1:0] q,
   output logic             ser_out,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_t           state_r, state_nxt_s;
   logic [2:0]       op_r, op_nxt_s;
   logic [CNT_W-1:0] count_r, count_nxt_s;
   logic             done_r, done_nxt_s;
   logic             err_r, err_nxt_s;
   logic             core_en_s;
   logic [2:0]       core_op_s;

   // in IDLE the core sees the offered opcode so CLR/LOAD land on the accept edge
   assign core_op_s = (state_r == ST_IDLE) ? cmd_op : op_r;

   // next-state, counter and pulse decode
   always_comb begin
      state_nxt_s = state_r;
      op_nxt_s    = op_r;
      count_nxt_s = count_r;
      done_nxt_s  = 1'b0;
      err_nxt_s   = 1'b0;
      core_en_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_nxt_s = cmd_op;
               case (cmd_op)
                  OP_CLR, OP_LOAD: begin
                     core_en_s   = 1'b1;
                     state_nxt_s = ST_DONE;
                     done_nxt_s  = 1'b1;
                  end
                  OP_SHR, OP_SHL, OP_ROR, OP_JOHN: begin
                     if (cmd_count != {CNT_W{1'b0}}) begin
                        state_nxt_s = ST_RUN;
                        count_nxt_s = cmd_count;
                     end else begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                     end
                  end
                  default: begin
                     state_nxt_s = ST_DONE;
                     done_nxt_s  = 1'b1;
                     err_nxt_s   = 1'b1;
                  end
               endcase
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            // abort suppresses the shift on its own edge, including the last one
            if (abort) begin
               state_nxt_s = ST_DONE;
               count_nxt_s = {CNT_W{1'b0}};
               done_nxt_s  = 1'b1;
               err_nxt_s   = 1'b1;
            end else begin
               core_en_s   = 1'b1;
               count_nxt_s = count_r - CNT_W'(1);
               if (count_r == CNT_W'(1)) begin
                  state_nxt_s = ST_DONE;
                  done_nxt_s  = 1'b1;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         op_r    <= OP_CLR;
         count_r <= {CNT_W{1'b0}};
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         op_r    <= op_nxt_s;
         count_r <= count_nxt_s;
         done_r  <= done_nxt_s;
         err_r   <= err_nxt_s;
      end
   end

   shift_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (core_en_s),
      .op        (core_op_s),
      .ser_in    (ser_in),
      .load_data (load_data),
      .q         (q),
      .ser_out   (ser_out)
   );

   assign cmd_ready = (state_r == ST_IDLE);
   assign busy      = (state_r != ST_IDLE);
   assign done      = done_r;
   assign err       = err_r;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Scoreboard bench for shift_reg_sequencer: directed scenarios plus random
// commands checked against an arithmetic reference model.
module tb_shift_reg_sequencer;
   import shift_seq_pkg::*;

   localparam int W   = 6;
   localparam int CW  = 4;
   localparam int MSB = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [2:0]    cmd_op = 3'b000;
   logic [CW-1:0] cmd_count = 4'd0;
   logic [W-1:0]  load_data = 6'd0;
   logic          ser_in = 1'b0;
   logic          abort = 1'b0;
   logic [W-1:0]  q;
   logic          ser_out, busy, done, err;

   shift_reg_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_count(cmd_count), .load_data(load_data),
      .ser_in(ser_in), .abort(abort), .q(q), .ser_out(ser_out),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] q;
      logic         err;
      int           done_cyc;
   } exp_t;

   exp_t         sbq[$];
   exp_t         mon_e;
   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   logic [W-1:0] mdl_q = 6'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // reference: one shift of the register value, written as plain arithmetic
   function automatic logic [W-1:0] ref_step(input logic [2:0] op, input logic [W-1:0] cur, input logic s);
      int v, b0, si;
      v = int'(cur); b0 = v % 2; si = int'(s);
      case (op)
         OP_SHR:  return W'(v / 2 + si * MSB);
         OP_SHL:  return W'((v * 2) % (2 * MSB) + si);
         OP_ROR:  return W'(v / 2 + (b0 | si) * MSB);
         OP_JOHN: return W'(v / 2 + ((1 - b0) | si) * MSB);
         default: return cur;
      endcase
   endfunction

   function automatic logic ref_serout(input logic [2:0] op, input logic [W-1:0] cur);
      case (op)
         OP_SHR, OP_ROR, OP_JOHN: return (int'(cur) % 2) == 1;
         OP_SHL:                  return (int'(cur) / MSB) == 1;
         default:                 return 1'b0;
      endcase
   endfunction

   // monitor: every done pulse pops one expectation
   always @(negedge clk) begin
      if (rst_n && done) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            mon_e = sbq.pop_front();
            check("done_q", 32'(q), 32'(mon_e.q));
            check("done_err", 32'(err), 32'(mon_e.err));
            check("done_cycle", 32'(cyc), 32'(mon_e.done_cyc));
         end
      end
   end

   task automatic do_cmd(input logic [2:0] op, input int cnt, input logic [W-1:0] data,
                         input logic [31:0] sbits, input int abort_at,
                         input bit hold_load, input logic [W-1:0] hold_data);
      bit           is_shift, aborted;
      int           shifts, lat, guard, i;
      exp_t         e;
      logic [W-1:0] mq;
      is_shift = (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_JOHN);
      aborted  = is_shift && cnt > 0 && abort_at >= 1 && abort_at <= cnt;
      shifts   = !is_shift ? 0 : (aborted ? abort_at - 1 : cnt);
      if (op == OP_CLR) e.q = 6'd0;
      else if (op == OP_LOAD) e.q = data;
      else begin
         e.q = mdl_q;
         for (int k = 0; k < shifts; k++) e.q = ref_step(op, e.q, sbits[k]);
      end
      e.err = (op[2:1] == 2'b11) || aborted;
      lat = (is_shift && cnt > 0) ? (aborted ? abort_at + 1 : cnt + 1) : 1;

      cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt[CW-1:0]; load_data = data;
      abort = 1'($urandom_range(0, 1));
      ser_in = 1'($urandom_range(0, 1));
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      if (!cmd_ready) begin
         checks++; errors++;
         $display("FAIL ready_timeout actual=0 required=1");
         cmd_valid = 1'b0;
         return;
      end
      e.done_cyc = cyc + lat;
      sbq.push_back(e);
      @(posedge clk); #1;
      if (hold_load) begin
         cmd_op = OP_LOAD; load_data = hold_data;
      end else begin
         cmd_valid = 1'b0;
      end
      abort = 1'b0;
      mq = (op == OP_CLR) ? 6'd0 : (op == OP_LOAD) ? data : mdl_q;
      i = 1;
      while (!done && i <= 20) begin
         ser_in = sbits[i-1];
         abort  = (i == abort_at);
         check("run_ser_out", 32'(ser_out), 32'(ref_serout(op, mq)));
         @(posedge clk); #1;
         if (i != abort_at) mq = ref_step(op, mq, sbits[i-1]);
         check("run_q", 32'(q), 32'(mq));
         i++;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL done_timeout actual=0 required=1");
      end
      abort  = 1'($urandom_range(0, 1));
      ser_in = 1'($urandom_range(0, 1));
      mdl_q  = e.q;
      @(posedge clk); #1;
      abort = 1'b0;
      check("idle_q", 32'(q), 32'(e.q));
      check("idle_ready", 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   op_i, cnt_i, ab_i;
      // reset state
      #12;
      check("rst_q", 32'(q), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // LOAD then SHR x3 with ser_in=1
      do_cmd(OP_LOAD, 0, 6'b101100, 32'd0, 0, 1'b0, 6'd0);
      do_cmd(OP_SHR, 3, 6'd0, 32'hFFFF_FFFF, 0, 1'b0, 6'd0);
      check("t2_q", 32'(q), 32'(6'b111101));

      // ring rotate full circle, then SHL from 110000
      do_cmd(OP_LOAD, 0, 6'b000001, 32'd0, 0, 1'b0, 6'd0);
      do_cmd(OP_ROR, 6, 6'd0, 32'd0, 0, 1'b0, 6'd0);
      check("t3_ror_q", 32'(q), 32'(6'b000001));
      do_cmd(OP_LOAD, 0, 6'b110000, 32'd0, 0, 1'b0, 6'd0);
      do_cmd(OP_SHL, 2, 6'd0, 32'd0, 0, 1'b0, 6'd0);
      check("t3_shl_q", 32'(q), 32'(6'b000000));

      // Johnson counter full period
      do_cmd(OP_LOAD, 0, 6'b011010, 32'd0, 0, 1'b0, 6'd0);
      do_cmd(OP_CLR, 0, 6'd0, 32'd0, 0, 1'b0, 6'd0);
      do_cmd(OP_JOHN, 12, 6'd0, 32'd0, 0, 1'b0, 6'd0);
      check("t4_john_q", 32'(q), 32'(6'b000000));

      // abort after one shift; illegal opcode
      do_cmd(OP_LOAD, 0, 6'b101100, 32'd0, 0, 1'b0, 6'd0);
      do_cmd(OP_SHR, 4, 6'd0, 32'd0, 2, 1'b0, 6'd0);
      check("t5_abort_q", 32'(q), 32'(6'b010110));
      do_cmd(3'b110, 5, 6'd0, 32'd0, 0, 1'b0, 6'd0);
      check("t5_illegal_q", 32'(q), 32'(6'b010110));
      // abort on the final shift edge
      do_cmd(OP_SHL, 3, 6'd0, 32'hFFFF_FFFF, 3, 1'b0, 6'd0);
      check("t5_abort_last_q", 32'(q), 32'(6'b011011));

      // zero count; command held during busy is taken once at IDLE
      do_cmd(OP_SHR, 0, 6'd0, 32'hFFFF_FFFF, 0, 1'b0, 6'd0);
      check("t6_zero_q", 32'(q), 32'(6'b011011));
      do_cmd(OP_SHR, 3, 6'd0, 32'd0, 0, 1'b1, 6'b100111);
      e.q = 6'b100111; e.err = 1'b0; e.done_cyc = cyc + 1;
      sbq.push_back(e);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      mdl_q = 6'b100111;
      repeat (4) @(posedge clk);
      #1;
      check("t6_hold_q", 32'(q), 32'(6'b100111));
      check("t6_hold_sb_empty", 32'(sbq.size()), 32'd0);

      // random commands
      for (int n = 0; n < 60; n++) begin
         op_i  = $urandom_range(0, 7);
         cnt_i = $urandom_range(0, 15);
         ab_i  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0;
         do_cmd(3'(op_i), cnt_i, 6'($urandom), $urandom, ab_i, 1'b0, 6'd0);
      end

      // asynchronous reset in the middle of a shift run
      do_cmd(OP_LOAD, 0, 6'b111111, 32'd0, 0, 1'b0, 6'd0);
      cmd_valid = 1'b1; cmd_op = OP_SHR; cmd_count = 4'd5;
      @(posedge clk); #1;
      cmd_valid = 1'b0; ser_in = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("t1_rst_q", 32'(q), 32'd0);
      check("t1_rst_busy", 32'(busy), 32'd0);
      check("t1_rst_ready", 32'(cmd_ready), 32'd1);
      check("t1_rst_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      mdl_q = 6'd0;
      repeat (8) @(posedge clk);
      #1;
      check("t1_post_q", 32'(q), 32'd0);
      check("t1_post_busy", 32'(busy), 32'd0);
      check("final_sb_empty", 32'(sbq.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
